// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
package imem_arb_pkg;

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } arb_state_t;

   localparam logic [1:0] ALIGN_MASK = 2'b11;
   localparam logic       MEM_RD     = 1'b1;
   localparam logic       MEM_WR     = 1'b0;

   // A word access is legal only when the two byte-offset bits are zero.
   function automatic logic is_misaligned(input logic [1:0] lsb);
      return (lsb & ALIGN_MASK) != 2'b00;
   endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive denied loader cycles.
module imem_starve_ctr (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   input  logic [3:0] limit,
   output logic [3:0] cnt,
   output logic       at_limit
);

   // Clear wins over increment; count stops once it reaches the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= 4'd0;
      else if (clr)
         cnt <= 4'd0;
      else if (inc && (cnt < limit))
         cnt <= cnt + 4'd1;
   end

   assign at_limit = (cnt == limit);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: loader-only during boot, then
// fetch-priority with a starvation guard for late loader writes.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_req,
   input  logic [ADDR_WIDTH-1:0] fetch_addr,
   output logic                  fetch_gnt,
   output logic                  fetch_rvalid,
   output logic [DATA_WIDTH-1:0] fetch_rdata,
   output logic                  fetch_err,
   input  logic                  load_req,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_wdata,
   input  logic                  load_done,
   output logic                  load_gnt,
   output logic                  load_err,
   output logic                  boot_done,
   output logic                  mem_en,
   output logic                  mem_rd_wr,
   output logic [ADDR_WIDTH-1:0] mem_read_addr,
   output logic [ADDR_WIDTH-1:0] mem_write_addr,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   arb_state_t state;
   logic       fetch_mis;
   logic       load_mis;
   logic [3:0] starve_cnt;
   logic       at_limit;

   assign fetch_mis = is_misaligned(fetch_addr[1:0]);
   assign load_mis  = is_misaligned(load_addr[1:0]);

   imem_starve_ctr u_starve (
      .clk      (clk),
      .rst      (rst),
      .inc      (load_req & ~load_gnt),
      .clr      (load_gnt),
      .limit    (LIMIT),
      .cnt      (starve_cnt),
      .at_limit (at_limit)
   );

   // Grant selection: loader owns boot; in run fetch wins unless the loader is starved.
   always_comb begin
      fetch_gnt = 1'b0;
      load_gnt  = 1'b0;
      if (!rst) begin
         if (state == BOOT)
            load_gnt = load_req;
         else if (load_req && (!fetch_req || at_limit))
            load_gnt = 1'b1;
         else
            fetch_gnt = fetch_req;
      end
   end

   // Memory port mux; misaligned grants leave the memory idle.
   always_comb begin
      mem_en         = 1'b0;
      mem_rd_wr      = MEM_RD;
      mem_read_addr  = '0;
      mem_write_addr = '0;
      mem_write_data = '0;
      if (fetch_gnt && !fetch_mis) begin
         mem_en        = 1'b1;
         mem_read_addr = fetch_addr;
      end else if (load_gnt && !load_mis) begin
         mem_en         = 1'b1;
         mem_rd_wr      = MEM_WR;
         mem_write_addr = load_addr;
         mem_write_data = load_wdata;
      end
   end

   // Boot sequencing: load_done is the only way out of BOOT; RUN is sticky.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= BOOT;
         boot_done <= 1'b0;
      end else if (state == BOOT && load_done) begin
         state     <= RUN;
         boot_done <= 1'b1;
      end
   end

   // Response register: one-cycle rvalid/err pulses, data captured on read grants.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_rvalid <= 1'b0;
         fetch_err    <= 1'b0;
         fetch_rdata  <= '0;
         load_err     <= 1'b0;
      end else begin
         fetch_rvalid <= fetch_gnt;
         fetch_err    <= fetch_gnt & fetch_mis;
         load_err     <= load_gnt & load_mis;
         if (fetch_gnt)
            fetch_rdata <= fetch_mis ? '0 : mem_read_data;
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a small behavioral memory.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_req = 1'b0;
   logic [31:0] fetch_addr = '0;
   logic        fetch_gnt, fetch_rvalid, fetch_err;
   logic [31:0] fetch_rdata;
   logic        load_req = 1'b0;
   logic [31:0] load_addr = '0;
   logic [31:0] load_wdata = '0;
   logic        load_done = 1'b0;
   logic        load_gnt, load_err, boot_done;
   logic        mem_en, mem_rd_wr;
   logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:15];

   always #5 clk = ~clk;

   imem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
      .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
      .load_req(load_req), .load_addr(load_addr), .load_wdata(load_wdata),
      .load_done(load_done), .load_gnt(load_gnt), .load_err(load_err),
      .boot_done(boot_done), .mem_en(mem_en), .mem_rd_wr(mem_rd_wr),
      .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   // Behavioral single-port memory: combinational read, write on the edge.
   assign mem_read_data = mem[mem_read_addr[5:2]];
   always @(posedge clk)
      if (mem_en && !mem_rd_wr)
         mem[mem_write_addr[5:2]] <= mem_write_data;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the next negedge and let combinational outputs settle.
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;

      // Reset state, with requests active to prove grants are forced low.
      cyc();
      fetch_req = 1'b1; load_req = 1'b1;
      #1;
      chk("rst_fetch_gnt", fetch_gnt, 0);
      chk("rst_load_gnt", load_gnt, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_rd_wr", mem_rd_wr, 1);
      chk("rst_rvalid", fetch_rvalid, 0);
      chk("rst_boot_done", boot_done, 0);
      chk("rst_load_err", load_err, 0);
      load_req = 1'b0;

      // Boot: write 0x0, fetch held at 0x0 and blocked.
      cyc();
      rst = 1'b0;
      fetch_addr = 32'h0;
      load_req = 1'b1; load_addr = 32'h0; load_wdata = 32'h00500093;
      #1;
      chk("boot_load_gnt", load_gnt, 1);
      chk("boot_fetch_gnt", fetch_gnt, 0);
      chk("boot_mem_en", mem_en, 1);
      chk("boot_rd_wr", mem_rd_wr, 0);
      chk("boot_waddr", mem_write_addr, 32'h0);
      chk("boot_wdata", mem_write_data, 32'h00500093);
      cyc();
      load_addr = 32'h4; load_wdata = 32'h11111111;
      #1 chk("boot_load_gnt2", load_gnt, 1);
      cyc();
      load_req = 1'b0;
      for (int i = 0; i < 7; i++) begin
         #1 chk("boot_fetch_blocked", fetch_gnt, 0);
         chk("boot_idle_en", mem_en, 0);
         cyc();
      end
      // Last boot write coincides with load_done.
      load_req = 1'b1; load_addr = 32'h8; load_wdata = 32'h22222222; load_done = 1'b1;
      #1;
      chk("done_load_gnt", load_gnt, 1);
      chk("done_fetch_gnt", fetch_gnt, 0);
      chk("done_boot_done", boot_done, 0);

      // First RUN cycle: fetch 0x0, then back-to-back 0x4, 0x8.
      cyc();
      load_req = 1'b0; load_done = 1'b0;
      fetch_addr = 32'h0;
      #1;
      chk("run_boot_done", boot_done, 1);
      chk("run_fetch_gnt", fetch_gnt, 1);
      chk("run_mem_en", mem_en, 1);
      chk("run_rd_wr", mem_rd_wr, 1);
      chk("run_raddr", mem_read_addr, 32'h0);
      cyc();
      fetch_addr = 32'h4;
      #1;
      chk("b2b0_rvalid", fetch_rvalid, 1);
      chk("b2b0_rdata", fetch_rdata, 32'h00500093);
      chk("b2b0_err", fetch_err, 0);
      chk("b2b1_gnt", fetch_gnt, 1);
      cyc();
      fetch_addr = 32'h8;
      #1;
      chk("b2b1_rvalid", fetch_rvalid, 1);
      chk("b2b1_rdata", fetch_rdata, 32'h11111111);
      cyc();
      fetch_req = 1'b0;
      #1;
      chk("b2b2_rvalid", fetch_rvalid, 1);
      chk("b2b2_rdata", fetch_rdata, 32'h22222222);
      chk("idle_en", mem_en, 0);
      chk("idle_rd_wr", mem_rd_wr, 1);
      chk("idle_raddr", mem_read_addr, 32'h0);
      chk("idle_wdata", mem_write_data, 32'h0);
      cyc();
      #1 chk("idle_rvalid", fetch_rvalid, 0);

      // load_done in RUN is ignored.
      load_done = 1'b1;
      cyc();
      load_done = 1'b0;
      #1 chk("run_sticky", boot_done, 1);

      // Starvation guard: fetch x4, load, repeated.
      fetch_req = 1'b1; fetch_addr = 32'hC;
      load_req = 1'b1; load_addr = 32'h10; load_wdata = 32'h33333333;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("starve_fetch_gnt", fetch_gnt, (i % 5) != 4);
         chk("starve_load_gnt", load_gnt, (i % 5) == 4);
         cyc();
      end
      fetch_req = 1'b0; load_req = 1'b0;
      #1 chk("starve_mem_wr", mem[4], 32'h33333333);

      // Misaligned fetch.
      cyc();
      fetch_req = 1'b1; fetch_addr = 32'h6;
      #1;
      chk("misf_gnt", fetch_gnt, 1);
      chk("misf_mem_en", mem_en, 0);
      cyc();
      fetch_req = 1'b0;
      #1;
      chk("misf_rvalid", fetch_rvalid, 1);
      chk("misf_err", fetch_err, 1);
      chk("misf_rdata", fetch_rdata, 32'h0);

      // Misaligned load into word 0 is dropped.
      load_req = 1'b1; load_addr = 32'h3; load_wdata = 32'hDEADBEEF;
      #1;
      chk("misl_gnt", load_gnt, 1);
      chk("misl_mem_en", mem_en, 0);
      cyc();
      load_req = 1'b0;
      fetch_req = 1'b1; fetch_addr = 32'h0;
      #1;
      chk("misl_err", load_err, 1);
      chk("misl_fetch_gnt", fetch_gnt, 1);
      cyc();
      fetch_req = 1'b0;
      #1;
      chk("misl_err_pulse", load_err, 0);
      chk("misl_mem_kept", fetch_rdata, 32'h00500093);
      chk("misl_rd_err", fetch_err, 0);

      // Write-then-read to the same address.
      load_req = 1'b1; load_addr = 32'h14; load_wdata = 32'h44444444;
      cyc();
      load_req = 1'b0;
      fetch_req = 1'b1; fetch_addr = 32'h14;
      cyc();
      fetch_req = 1'b0;
      #1;
      chk("wtr_rvalid", fetch_rvalid, 1);
      chk("wtr_rdata", fetch_rdata, 32'h44444444);

      // Reset while a read response is pending.
      fetch_req = 1'b1; fetch_addr = 32'h4;
      #1 chk("rstmid_gnt", fetch_gnt, 1);
      @(posedge clk);
      #2;
      chk("rstmid_pre_rvalid", fetch_rvalid, 1);
      rst = 1'b1;
      #1;
      chk("rstmid_rvalid", fetch_rvalid, 0);
      chk("rstmid_boot_done", boot_done, 0);
      chk("rstmid_fetch_gnt", fetch_gnt, 0);
      cyc();
      rst = 1'b0;
      load_req = 1'b1; load_addr = 32'h18; load_wdata = 32'h55555555;
      #1;
      chk("reboot_fetch_gnt", fetch_gnt, 0);
      chk("reboot_load_gnt", load_gnt, 1);
      cyc();
      load_req = 1'b0; fetch_req = 1'b0;
      #1 chk("reboot_boot_done", boot_done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

- Shares the single-port instruction memory between two requesters:
  - the fetch stage, which only reads;
  - the program loader, which only writes.
- Sits between the fetch stage, the loader and the byte-addressed instruction memory, and drives that memory's control, address and data inputs.
- Sequences boot: the loader has exclusive access until the program is loaded, then fetch has priority with a starvation guard for late loader writes.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- STARVE_LIMIT, 4, consecutive denied loader cycles before the loader is forced a grant (range 1-15)

- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- fetch_req  in  1  fetch read request; held until granted
- fetch_addr  in  ADDR_WIDTH  fetch byte address
- fetch_gnt  out  1  combinational; request accepted this cycle
- fetch_rvalid  out  1  registered; read response valid, one-cycle pulse
- fetch_rdata  out  DATA_WIDTH  registered read data
- fetch_err  out  1  registered; qualifies fetch_rvalid, misaligned address
- load_req  in  1  loader write request; held until granted
- load_addr  in  ADDR_WIDTH  loader byte address
- load_wdata  in  DATA_WIDTH  loader write word
- load_done  in  1  pulse: program image complete
- load_gnt  out  1  combinational; write accepted this cycle
- load_err  out  1  registered; one-cycle pulse, misaligned write dropped
- boot_done  out  1  registered; high once in RUN
- mem_en  out  1  memory enable
- mem_rd_wr  out  1  1 = read, 0 = write
- mem_read_addr  out  ADDR_WIDTH  memory read address
- mem_write_addr  out  ADDR_WIDTH  memory write address
- mem_write_data  out  DATA_WIDTH  memory write data
- mem_read_data  in  DATA_WIDTH  combinational read data from memory

## Operation

**States: BOOT (reset state) and RUN.**

- **BOOT:**
  - fetch_gnt is 0.
  - load_req is granted every cycle.
  - load_done moves the arbiter to RUN at the next edge.
  - A load_req in the same cycle as load_done is still granted and written.
- **RUN:**
  - At most one access per cycle.
  - Fetch wins when both request, unless starve_cnt equals STARVE_LIMIT; the loader then wins that cycle.
  - load_done is ignored.
  - There is no path from RUN back to BOOT except rst.
- **starve_cnt:**
  - Increments when load_req is denied, saturating at STARVE_LIMIT.
  - Clears on any load grant.
- **Read grant:**
  - Drives mem_en=1, mem_rd_wr=1, mem_read_addr=fetch_addr.
  - mem_read_data is registered into fetch_rdata; fetch_rvalid is high the next cycle.
- **Write grant:**
  - Drives mem_en=1, mem_rd_wr=0, mem_write_addr=load_addr, mem_write_data=load_wdata.
  - The memory commits the write on the same edge.
- **Idle cycle:**
  - mem_en=0, mem_rd_wr=1.
  - Address and data outputs are 0.
- **Misaligned fetch (addr[1:0]≠0), when granted:**
  - No memory access: mem_en stays 0.
  - Next cycle: fetch_rvalid=1, fetch_err=1, fetch_rdata=0.
- **Misaligned load, when granted:**
  - No memory access.
  - load_err pulses next cycle.
  - It still counts as a grant for starve_cnt.
- **Outputs and width rules:**
  - Grants are purely combinational from req, state and starve_cnt.
  - There are no combinational paths from rdata to any req.
  - starve_cnt is 4 bits.
  - Addresses pass through unmodified.

## Timing
- **Reset values:** state=BOOT, starve_cnt=0, fetch_rvalid=0, fetch_rdata=0, fetch_err=0, load_err=0, boot_done=0.
- **Forced low during rst:** fetch_gnt, load_gnt, mem_en; also mem_rd_wr=1.
- **Latency:**
  - Read: request granted in cycle N, data valid in cycle N+1.
  - Write: committed at the end of the grant cycle.
- **Throughput:** back-to-back fetch reads give one rvalid per cycle.
- **Write-then-read to the same address:** the read in the cycle after the write returns the new data.
- **Reset mid-operation:**
  - A pending rvalid is cleared immediately (asynchronous).
  - A write granted in the cycle rst rises is not guaranteed.
- **boot_done** rises at the edge that enters RUN.

## Structure
- **Package imem_arb_pkg:**
  - state typedef {BOOT, RUN};
  - ALIGN_MASK = 2'b11;
  - MEM_RD = 1'b1 and MEM_WR = 1'b0.
- **Sub-module imem_starve_ctr:**
  - Saturating counter with inputs inc, clr and limit.
  - Outputs cnt and at_limit.
  - Instantiated once.
- **Top:** FSM, grant logic, memory mux and response register.

## Test plan
1. **Boot write, then done:**
   - Stimulus: rst released; load_req with addr 0x0 / data 0x00500093, then load_done.
   - Required: load_gnt=1 and a write to 0x0.
   - Required: boot_done=1 one cycle later; fetch to 0x0 returns rvalid with 0x00500093.
2. **Fetch blocked in BOOT:**
   - Stimulus: fetch_req held during BOOT for 10 cycles.
   - Required: fetch_gnt=0 throughout; first grant in the first RUN cycle.
3. **Starvation guard:**
   - Stimulus: in RUN, fetch_req and load_req held continuously with STARVE_LIMIT=4.
   - Required: grants follow fetch×4, load, fetch×4, load, and so on.
4. **Misaligned accesses:**
   - Stimulus: fetch_addr 0x6.
   - Required: mem_en=0; next cycle rvalid=1, err=1, rdata=0.
   - Stimulus: load_addr 0x3.
   - Required: load_err pulse; memory at 0x0 is unchanged.
5. **Back-to-back reads:** fetch addresses 0x0, 0x4, 0x8 on consecutive cycles give three consecutive rvalids with the matching words.
6. **Reset mid-read:**
   - Stimulus: rst asserted the cycle after a read grant.
   - Required: fetch_rvalid=0 immediately; state returns to BOOT; boot_done=0.
